// File: rtl/refill_pkg.sv
// Shared types and constants for the miss-refill controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package refill_pkg;

  // Controller states: idle/arbitrating, waiting for the memory line, writing the cache.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2
  } state_t;

  // Requester identity; also the encoding of the round-robin history bit.
  typedef logic grant_t;
  localparam grant_t GNT_I = 1'b0;
  localparam grant_t GNT_D = 1'b1;

  localparam int LINE_W = 128;

  // I-cache tag word layout: {valid, lru[2:0], line address, 2'b00}.
  localparam int VALID_BIT = 8;
  localparam int LRU_HI    = 7;
  localparam int LRU_LO    = 5;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the I-miss and D-miss requesters.
// Latency: grant is combinational; history updates on the clock after an advance strobe.
// Backpressure: none; the grant is only consumed when advance is high.
//   clk, reset      : clock and synchronous active-high reset
//   reqI, reqD      : request levels
//   advance         : caller accepted the current grant this cycle
//   gntValid/gntSel : some request is present / which one wins
module rr_arb2
  import refill_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   reqI,
  input  logic   reqD,
  input  logic   advance,
  output logic   gntValid,
  output grant_t gntSel
);

  grant_t lastGrant;

  // History starts at D so that I wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= GNT_D;
    end else if (advance && gntValid) begin
      lastGrant <= gntSel;
    end
  end

  always_comb begin
    gntValid = reqI | reqD;
    gntSel   = GNT_I;
    if (reqI && reqD) begin
      gntSel = (lastGrant == GNT_I) ? GNT_D : GNT_I;
    end else if (reqD) begin
      gntSel = GNT_D;
    end
  end

endmodule

// File: rtl/mem_refill_ctrl.sv
// Services I-cache and D-cache misses with one 128b line read each from a shared memory port.
// Latency: miss seen at edge N -> mem_req from N+1; mem_ready at edge M -> cache write in cycle M+1.
// Backpressure: misses are levels and are re-sampled in IDLE; a WAIT longer than TIMEOUT aborts.
//   imiss/imiss_pc, dmiss/dmiss_addr : miss levels and addresses from fetch / memory stage
//   mem_req/mem_addr, mem_ready/mem_rdata : line read port to main memory
//   icache_*/dcache_* : one-cycle line + tag write to the granted cache
//   fetch_stall/mem_stall : stage stalls;  mem_err : sticky timeout flag
module mem_refill_ctrl #(
  parameter int IADDR_W = 5,
  parameter int DADDR_W = 8,
  parameter int LINE_W  = refill_pkg::LINE_W,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imiss,
  input  logic [IADDR_W-1:0] imiss_pc,
  input  logic               dmiss,
  input  logic [DADDR_W-1:0] dmiss_addr,
  output logic               mem_req,
  output logic [DADDR_W-3:0] mem_addr,
  input  logic               mem_ready,
  input  logic [LINE_W-1:0]  mem_rdata,
  output logic               icache_we,
  output logic [LINE_W-1:0]  icache_line,
  output logic [8:0]         icache_tag,
  output logic               dcache_we,
  output logic [LINE_W-1:0]  dcache_line,
  output logic [DADDR_W+1:0] dcache_tag,
  output logic               fetch_stall,
  output logic               mem_stall,
  output logic               mem_err
);
  import refill_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state, stateNext;
  grant_t             grantR;
  grant_t             gntSel;
  logic               gntValid;
  logic               arbAdvance;
  logic               cntDone;
  logic [CNT_W-1:0]   timeoutCnt;
  logic               memReq;
  logic [DADDR_W-3:0] memAddr;
  logic [LINE_W-1:0]  lineR;
  logic [8:0]         iTagR;
  logic [DADDR_W+1:0] dTagR;
  logic               iWe, dWe, errR;
  logic [8:0]         iTagNext;

  // Word-offset bits do not select a line.
  logic unusedOffsetBits;
  assign unusedOffsetBits = &{1'b0, imiss_pc[1:0], dmiss_addr[1:0]};

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .reqI     (imiss),
    .reqD     (dmiss),
    .advance  (arbAdvance),
    .gntValid (gntValid),
    .gntSel   (gntSel)
  );

  assign cntDone = (timeoutCnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (gntValid) stateNext = WAIT;
      WAIT: begin
        if (mem_ready)    stateNext = FILL;
        else if (cntDone) stateNext = IDLE;
      end
      FILL:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Combinational outputs: arbitration strobe and stage stalls.
  always_comb begin
    arbAdvance  = (state == IDLE);
    fetch_stall = imiss | ((state != IDLE) && (grantR == GNT_I));
    mem_stall   = dmiss | ((state != IDLE) && (grantR == GNT_D));
  end

  // I tag is built from the low bits of the held line address, which were zero-extended from the PC.
  always_comb begin
    iTagNext                          = '0;
    iTagNext[VALID_BIT]               = 1'b1;
    iTagNext[LRU_HI:LRU_LO]           = 3'b000;
    iTagNext[LRU_LO-1 -: IADDR_W-2]   = memAddr[IADDR_W-3:0];
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grantR     <= GNT_I;
      timeoutCnt <= '0;
      memReq     <= 1'b0;
      memAddr    <= '0;
      lineR      <= '0;
      iTagR      <= '0;
      dTagR      <= '0;
      iWe        <= 1'b0;
      dWe        <= 1'b0;
      errR       <= 1'b0;
    end else begin
      iWe <= 1'b0;
      dWe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gntValid) begin
            grantR     <= gntSel;
            memReq     <= 1'b1;
            timeoutCnt <= '0;
            memAddr    <= (gntSel == GNT_I)
                          ? {{(DADDR_W-IADDR_W){1'b0}}, imiss_pc[IADDR_W-1:2]}
                          : dmiss_addr[DADDR_W-1:2];
          end
        end
        WAIT: begin
          if (mem_ready) begin
            lineR  <= mem_rdata;
            iTagR  <= iTagNext;
            dTagR  <= {1'b1, 3'b000, memAddr};
            memReq <= 1'b0;
            iWe    <= (grantR == GNT_I);
            dWe    <= (grantR == GNT_D);
          end else if (cntDone) begin
            errR   <= 1'b1;
            memReq <= 1'b0;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = memReq;
  assign mem_addr    = memAddr;
  assign icache_we   = iWe;
  assign icache_line = lineR;
  assign icache_tag  = iTagR;
  assign dcache_we   = dWe;
  assign dcache_line = lineR;
  assign dcache_tag  = dTagR;
  assign mem_err     = errR;

endmodule
